// File: rtl/systolic_c_drain.sv
// systolic_c_drain
// South-edge drain for the systolic array. Each column result stream lands
// in its own small circular FIFO. Once every column holds at least one
// entry, one entry is popped from each column into an aligned output row.
// Rows leave on a single valid/ready port. A row counter tracks the
// position inside an N-row tile and pulses tile_done after the last row.
// Optional build macro: DRAIN_SAT_EN clamps each popped value to the signed
// OUT_W range and sign-extends it back to ACC_W.
module systolic_c_drain #(
  parameter int N     = 4,
  parameter int ACC_W = 32,
  parameter int DEPTH = 4,
  parameter int OUT_W = 16,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W = PTR_W + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    flush,
  input  logic signed [ACC_W-1:0] c_south [N],
  input  logic [N-1:0]            c_valid,
  output logic [N-1:0]            c_ready,
  output logic [N*ACC_W-1:0]      row_data,
  output logic                    row_valid,
  input  logic                    row_ready,
  output logic [IDX_W-1:0]        row_idx,
  output logic                    tile_done,
  output logic [OCC_W-1:0]        occ [N]
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_PRESENT} state_t;

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((longint'(1) << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  logic signed [ACC_W-1:0] mem_q [N][DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q [N];
  logic [PTR_W-1:0]        wr_ptr_d [N];
  logic [PTR_W-1:0]        rd_ptr_q [N];
  logic [PTR_W-1:0]        rd_ptr_d [N];
  logic [OCC_W-1:0]        occ_q [N];
  logic [OCC_W-1:0]        occ_d [N];
  logic [N-1:0]            push;
  logic [N-1:0]            not_empty;
  logic                    alive_q;
  logic                    live;
  logic                    fire;
  logic                    accept;
  logic                    any_d;
  state_t                  state_q, state_d;
  logic [N*ACC_W-1:0]      row_data_q, row_data_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    tile_done_q, tile_done_d;

  // Clamp to the signed OUT_W range, result sign-extended to ACC_W.
  function automatic logic signed [ACC_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
    if (v > SAT_HI) return SAT_HI;
    else if (v < SAT_LO) return SAT_LO;
    else return v;
  endfunction

  // Value shaping applied to every popped entry.
  function automatic logic signed [ACC_W-1:0] shape(input logic signed [ACC_W-1:0] v);
`ifdef DRAIN_SAT_EN
    return sat_out(v);
`else
    return v;
`endif
  endfunction

  assign row_valid = (state_q == S_PRESENT);

  // Column handshakes, row fire decision and next FIFO pointer/occupancy state.
  // alive_q keeps ready low during reset and for the first edge after it.
  always_comb begin
    live      = alive_q & en & ~flush;
    push      = '0;
    not_empty = '0;
    c_ready   = '0;
    for (int i = 0; i < N; i++) begin
      not_empty[i] = (occ_q[i] != '0);
      c_ready[i]   = live & (occ_q[i] != OCC_W'(DEPTH));
      push[i]      = c_valid[i] & c_ready[i];
    end
    fire   = live & (&not_empty) & (~row_valid | row_ready);
    accept = live & row_valid & row_ready;
    any_d  = 1'b0;
    for (int i = 0; i < N; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(fire);
      occ_d[i]    = occ_q[i] + OCC_W'(push[i]) - OCC_W'(fire);
      if (flush) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
        occ_d[i]    = '0;
      end
      any_d = any_d | (occ_d[i] != '0);
    end
  end

  // Output row register, row counter and tile completion pulse.
  always_comb begin
    row_data_d  = row_data_q;
    idx_d       = idx_q;
    tile_done_d = accept & (idx_q == IDX_W'(N - 1));
    if (fire) begin
      for (int i = 0; i < N; i++) begin
        row_data_d[i*ACC_W +: ACC_W] = shape(mem_q[i][rd_ptr_q[i]]);
      end
    end
    if (accept) begin
      idx_d = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + 1'b1;
    end
    if (flush) begin
      idx_d       = '0;
      tile_done_d = 1'b0;
    end
  end

  // Drain state: PRESENT while a row is held, otherwise COLLECT/IDLE by occupancy.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else if (live) begin
      if (fire) state_d = S_PRESENT;
      else if (row_valid && !row_ready) state_d = S_PRESENT;
      else state_d = any_d ? S_COLLECT : S_IDLE;
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      alive_q     <= 1'b0;
      state_q     <= S_IDLE;
      idx_q       <= '0;
      tile_done_q <= 1'b0;
      row_data_q  <= '0;
      for (int i = 0; i < N; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        occ_q[i]    <= '0;
      end
    end else begin
      alive_q     <= 1'b1;
      state_q     <= state_d;
      idx_q       <= idx_d;
      tile_done_q <= tile_done_d;
      row_data_q  <= row_data_d;
      for (int i = 0; i < N; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        occ_q[i]    <= occ_d[i];
      end
    end
  end

  // Column storage: written on push only; contents beyond occupancy are don't-care.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= c_south[i];
    end
  end

  assign row_data  = row_data_q;
  assign row_idx   = idx_q;
  assign tile_done = tile_done_q;
  assign occ       = occ_q;

endmodule

// File: tb/tb_systolic_c_drain.sv
// Bench for systolic_c_drain: per-column source queues drive the columns,
// a queue-based reference model predicts rows, and a monitor pops expected
// rows from a scoreboard whenever the DUT hands a row downstream.
module tb_systolic_c_drain;
  localparam int N = 4;
  localparam int W = 32;
  localparam int DEPTH = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                en = 1'b1;
  logic                flush = 1'b0;
  logic signed [W-1:0] c_south [N];
  logic [N-1:0]        c_valid = '0;
  logic [N-1:0]        c_ready;
  logic [N*W-1:0]      row_data;
  logic                row_valid;
  logic                row_ready = 1'b1;
  logic [1:0]          row_idx;
  logic                tile_done;
  logic [2:0]          occ [N];

  systolic_c_drain #(.N(N), .ACC_W(W), .DEPTH(DEPTH), .OUT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .c_south(c_south), .c_valid(c_valid), .c_ready(c_ready),
    .row_data(row_data), .row_valid(row_valid), .row_ready(row_ready),
    .row_idx(row_idx), .tile_done(tile_done), .occ(occ)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // stimulus sources and reference model state
  int             src [N][$];
  int             dly [N];
  int             valid_pct = 100;
  bit             rr_rand = 1'b0;
  int             mq [N][$];
  bit             m_valid = 1'b0;
  int             m_cnt = 0;
  bit             m_td = 1'b0;
  bit             m_alive = 1'b0;
  logic [N*W-1:0] exp_d [$];
  int             exp_i [$];
  int             rows_seen = 0;
  int             seen0 [$];

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, expv);
    end
  endtask

  function automatic int shape(input int v);
`ifdef DRAIN_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
`endif
    return v;
  endfunction

  function automatic bit m_ready(input int i);
    return m_alive && en && !flush && (mq[i].size() < DEPTH);
  endfunction

  // Reference model: compare DUT state, then advance by one clock edge.
  always @(negedge clk) begin
    bit rdy [N];
    bit acc, all_ne, fr;
    logic [N*W-1:0] r;
    if (rst_n) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_valid = 0; m_cnt = 0; m_td = 0; m_alive = 0;
      exp_d.delete(); exp_i.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        chk("c_ready", c_ready[i], m_ready(i));
        chk("occ", occ[i], mq[i].size());
      end
      chk("row_valid", row_valid, m_valid);
      chk("row_idx", row_idx, m_cnt);
      chk("tile_done", tile_done, m_td);
      if (flush) begin
        for (int i = 0; i < N; i++) mq[i].delete();
        m_valid = 0; m_cnt = 0; m_td = 0;
        exp_d.delete(); exp_i.delete();
      end else if (en && m_alive) begin
        for (int i = 0; i < N; i++) rdy[i] = mq[i].size() < DEPTH;
        acc = m_valid && row_ready;
        all_ne = 1;
        for (int i = 0; i < N; i++) if (mq[i].size() == 0) all_ne = 0;
        fr = all_ne && (!m_valid || row_ready);
        m_td = acc && (m_cnt == N - 1);
        if (acc) m_cnt = (m_cnt + 1) % N;
        if (fr) begin
          for (int i = 0; i < N; i++) r[i*W +: W] = shape(mq[i].pop_front());
          exp_d.push_back(r);
          exp_i.push_back(m_cnt);
          m_valid = 1;
        end else if (acc) begin
          m_valid = 0;
        end
        for (int i = 0; i < N; i++) begin
          if (c_valid[i] && rdy[i]) begin
            mq[i].push_back(c_south[i]);
            void'(src[i].pop_front());
          end
        end
      end else begin
        m_td = 0;
      end
      m_alive = 1;
    end
  end

  // Monitor: every row handed downstream is checked against the scoreboard.
  always @(negedge clk) begin
    logic [N*W-1:0] d;
    int ix;
    if (!rst_n && en && !flush && row_valid && row_ready) begin
      if (exp_d.size() == 0) begin
        chk("row_unexpected", row_data, 'x);
      end else begin
        d = exp_d.pop_front();
        ix = exp_i.pop_front();
        chk("row_data", row_data, d);
        chk("row_idx_out", row_idx, ix);
      end
      rows_seen++;
      seen0.push_back(int'(row_data[W-1:0]));
    end
  end

  // Driver: present the head of each source queue, honouring start delays.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      c_south[i] = $urandom;
      if (dly[i] > 0) begin
        dly[i]--;
        c_valid[i] = 1'b0;
      end else if (src[i].size() > 0 && ($urandom_range(99) < valid_pct)) begin
        c_valid[i] = 1'b1;
        c_south[i] = src[i][0];
      end else begin
        c_valid[i] = 1'b0;
      end
    end
    if (rr_rand) row_ready = $urandom_range(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic bit busy();
    for (int i = 0; i < N; i++) if (src[i].size() != 0 || mq[i].size() != 0) return 1;
    return m_valid;
  endfunction

  // Pad columns so every column ends with the same number of pending entries.
  task automatic balance();
    int mx = 0;
    for (int i = 0; i < N; i++) if (src[i].size() + mq[i].size() > mx) mx = src[i].size() + mq[i].size();
    for (int i = 0; i < N; i++)
      while (src[i].size() + mq[i].size() < mx) src[i].push_back($urandom);
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (busy() && n < maxc) begin
      tick(1);
      n++;
    end
    chk("drain_timeout", busy(), 0);
  endtask

  initial begin
    int base;
    int n;
    for (int i = 0; i < N; i++) begin
      dly[i] = 0;
      c_south[i] = '0;
    end
    // reset values while reset is held
    tick(2);
    for (int i = 0; i < N; i++) begin
      chk("rst_c_ready", c_ready[i], 0);
      chk("rst_occ", occ[i], 0);
    end
    chk("rst_row_data", row_data, 0);
    chk("rst_row_valid", row_valid, 0);
    chk("rst_row_idx", row_idx, 0);
    chk("rst_tile_done", tile_done, 0);
    rst_n = 1'b0;
    tick(2);

    // skewed fill: column i pushes 10*i+r, starting i cycles late
    base = rows_seen;
    seen0.delete();
    for (int i = 0; i < N; i++) begin
      dly[i] = i;
      for (int r = 0; r < 4; r++) src[i].push_back(10 * i + r);
    end
    drain(40);
    tick(2);
    chk("skew_rows", rows_seen - base, 4);
    for (int r = 0; r < 4; r++) chk("skew_col0", seen0[r], r);

    // backpressure: 5 entries per column with downstream stalled
    row_ready = 1'b0;
    for (int i = 0; i < N; i++)
      for (int r = 0; r < 5; r++) src[i].push_back(100 * i + r);
    tick(12);
    for (int i = 0; i < N; i++) begin
      chk("bp_occ", occ[i], 4);
      chk("bp_c_ready", c_ready[i], 0);
    end
    chk("bp_row_valid", row_valid, 1);
    row_ready = 1'b1;
    drain(40);

    // partial row: column 3 silent
    for (int i = 0; i < 3; i++) src[i].push_back(7 + i);
    tick(6);
    chk("partial_row_valid", row_valid, 0);
    src[3].push_back(9);
    drain(20);

    // flush mid-tile after two rows accepted
    for (int i = 0; i < N; i++)
      for (int r = 0; r < 8; r++) src[i].push_back($urandom);
    base = rows_seen;
    n = 0;
    while (rows_seen - base < 2 && n < 50) begin
      tick(1);
      n++;
    end
    chk("flush_wait_timeout", rows_seen - base >= 2, 1);
    row_ready = 1'b0;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    for (int i = 0; i < N; i++) chk("flush_occ", occ[i], 0);
    chk("flush_row_idx", row_idx, 0);
    chk("flush_row_valid", row_valid, 0);
    row_ready = 1'b1;
    balance();
    drain(60);

    // asynchronous reset pulse mid-stream
    for (int i = 0; i < N; i++)
      for (int r = 0; r < 6; r++) src[i].push_back($urandom);
    tick(3);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      chk("arst_occ", occ[i], 0);
      chk("arst_c_ready", c_ready[i], 0);
    end
    chk("arst_row_valid", row_valid, 0);
    chk("arst_row_idx", row_idx, 0);
    chk("arst_tile_done", tile_done, 0);
    chk("arst_row_data", row_data, 0);
    for (int i = 0; i < N; i++) src[i].delete();
    tick(2);
    rst_n = 1'b0;
    tick(2);

    // en=0 freezes state and refuses pushes
    for (int i = 0; i < 2; i++) begin
      src[i].push_back(50 + i);
      src[i].push_back(60 + i);
    end
    tick(4);
    en = 1'b0;
    for (int i = 0; i < N; i++) src[i].push_back(70 + i);
    tick(4);
    for (int i = 0; i < N; i++) chk("en0_c_ready", c_ready[i], 0);
    en = 1'b1;
    balance();
    drain(40);

    // saturation boundary values on every column
    seen0.delete();
    for (int i = 0; i < N; i++) begin
      src[i].push_back(70000);
      src[i].push_back(-70000);
      src[i].push_back(5);
      src[i].push_back(-5);
    end
    drain(40);
    tick(2);
    chk("sat_rows", seen0.size(), 4);
`ifdef DRAIN_SAT_EN
    chk("sat_pos", seen0[0], 32767);
    chk("sat_neg", seen0[1], -32768);
`else
    chk("sat_pos", seen0[0], 70000);
    chk("sat_neg", seen0[1], -70000);
`endif
    chk("sat_small_pos", seen0[2], 5);
    chk("sat_small_neg", seen0[3], -5);

    // randomized traffic with stalls, gaps, enable drops and flushes
    valid_pct = 70;
    rr_rand = 1'b1;
    for (int i = 0; i < N; i++)
      for (int r = 0; r < 60; r++) src[i].push_back($urandom);
    for (int c = 0; c < 300; c++) begin
      en = ($urandom_range(9) != 0);
      flush = ($urandom_range(49) == 0);
      tick(1);
    end
    en = 1'b1;
    flush = 1'b0;
    rr_rand = 1'b0;
    row_ready = 1'b1;
    valid_pct = 100;
    tick(1);
    balance();
    drain(400);
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_c_drain.md
# systolic_c_drain

Receive-side drain for the systolic array's south edge: accepts the N per-column result streams (`c_south`/`c_valid`/`c_ready`) that leave the array skewed in time. It buffers each column in a small FIFO and reassembles aligned output rows of N accumulators. Rows go out on a single valid/ready port toward tile writeback. It also tracks the row index inside an N-row tile and pulses on tile completion.

## Interface
- `N`, 4: array dimension; number of columns and rows per tile.
- `ACC_W`, 32: accumulator width, signed.
- `DEPTH`, 4: per-column FIFO depth; power of two, at least 2, at least N recommended to absorb full skew.
- `OUT_W`, 16: saturation width used only when `DRAIN_SAT_EN` is defined.

Ports:
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-high.
- `en` input 1: drain enable.
- `flush` input 1: synchronous clear of all buffered data and the row counter.
- `c_south[N]` input ACC_W signed: per-column result from the array.
- `c_valid[N]` input 1: per-column valid.
- `c_ready[N]` output 1: per-column ready.
- `row_data` output N*ACC_W: column i in bits [i*ACC_W +: ACC_W].
- `row_valid` output 1: row available.
- `row_ready` input 1: downstream accept.
- `row_idx` output $clog2(N): row number of the current `row_data` within the tile.
- `tile_done` output 1: one-cycle pulse when row N-1 is accepted.
- `occ[N]` output $clog2(DEPTH)+1: per-column FIFO occupancy, for debug.

## Operation
- Each column has an independent circular FIFO with write pointer, read pointer and an occupancy counter.
- `c_ready[i] = en & !flush & (occ[i] != DEPTH)`. Ready never depends on a same-cycle pop, so a full FIFO refuses a push even while it is popping.
- A push to column i happens at a clock edge when `c_valid[i] & c_ready[i]`. Pointers wrap modulo DEPTH.
- `row_fire = en & !flush & (all occ[i] != 0) & (!row_valid | row_ready)`.
- On `row_fire`, every column pops exactly one entry into the `row_data` register and `row_valid` is set.
- Output register behaviour:
  - Accept with no new fire: `row_valid & row_ready & !row_fire` clears `row_valid`.
  - Accept and fire together: a back-to-back transfer, with `row_valid` staying 1.
- Row counter:
  - Advances on each accepted row, wrapping N-1 to 0.
  - `tile_done` is 1 in the cycle after the accept of row N-1.
  - `row_idx` shows the index of the row currently held.
- State, derived from the counter and `row_valid`:
  - IDLE: all FIFOs empty, `row_valid=0`.
  - COLLECT: some FIFOs non-empty but not all.
  - PRESENT: `row_valid=1`.
  - Transitions follow the rules above.
- Partial rows are never emitted. Data stays in the FIFOs until every column has contributed.
- `en=0` freezes all state: no push, no pop, and outputs are held.
- `flush`, and `rst_n` asserted at any time, including mid-tile:
  - All occupancies and pointers go to 0.
  - `row_valid` goes to 0 and `row_idx` goes to 0.
  - Data in flight is discarded.
  - `flush` outranks a simultaneous push or fire.
- Simultaneous push and pop on the same column is legal: occupancy is unchanged and the data order is preserved.

## Timing
- Reset values: `c_ready` 0 for all columns, `row_data` 0, `row_valid` 0, `row_idx` 0, `tile_done` 0, `occ` 0.
- After reset deasserts and with `en=1`, `c_ready` is 1 from the next cycle.
- Latency: a push at edge k that completes a row makes `row_data`/`row_valid` change at edge k+1, when the output register is free.
- Throughput: one row per cycle while all FIFOs hold data and `row_ready=1`.
- `row_data` and `row_idx` are stable while `row_valid & !row_ready`.

## Configuration
- `DRAIN_SAT_EN` defined:
  - Each popped value is clamped to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - The clamped value is sign-extended to ACC_W.
  - Example with OUT_W=16: 40000 becomes 32767, and -40000 becomes -32768.
- `DRAIN_SAT_EN` undefined: values pass through unmodified at full ACC_W.

## Test plan
- Skewed fill, N=4: column i pushes values 10*i+r for r=0..3, starting i cycles late, with `row_ready=1`.
  - Required: 4 rows {r, 10+r, 20+r, 30+r}.
  - `row_idx` runs 0..3.
  - `tile_done` is a single pulse after row 3.
- Backpressure with `row_ready=0` while columns push 5 entries each, DEPTH=4:
  - `c_ready` drops once occ reaches 4, with one row held in the output register.
  - After release, all rows come out in order with no loss or duplication.
- Partial column: columns 0-2 push, column 3 does not.
  - `row_valid` stays 0.
  - A later push on column 3 produces `row_valid` at the next edge.
- Flush mid-tile after 2 rows accepted with FIFOs non-empty:
  - occ goes to 0, `row_idx` goes to 0, `row_valid` goes to 0.
  - The next full tile restarts at `row_idx` 0.
- Async reset pulse mid-stream: all outputs reach their reset values without a clock edge. With `en=0`, pushes are refused and state is held.
- With `DRAIN_SAT_EN` and OUT_W=16: pushing 70000, -70000, 5, -5 yields 32767, -32768, 5, -5. Without the macro, the same values pass through unchanged.
